// File: rtl/vga_rx_timing_recovery_if.sv
// Bundle between a VGA-timed source and the timing-recovery receiver.
//   vga_hsync_in / vga_vsync_in : incoming syncs, active low
//   vga_rgb_in                  : incoming pixel, RRRGGGBB
//   rx_*                        : recovered coordinates, data-enable and pixel
//   frame_start                 : first active pixel of each locked frame
//   locked / timing_err         : lock status and 1-cycle length-violation pulse
//   err_count                   : saturating count of timing_err pulses
//   meas_line_len / meas_frame_lines : last measured line / frame length
// master: the source side (drives the syncs, observes the recovery results).
// slave : the receiver.
interface vga_rx_timing_recovery_if;
  logic       vga_hsync_in;
  logic       vga_vsync_in;
  logic [7:0] vga_rgb_in;
  logic [9:0] rx_x;
  logic [9:0] rx_y;
  logic       rx_de;
  logic [7:0] rx_rgb;
  logic       frame_start;
  logic       locked;
  logic       timing_err;
  logic [7:0] err_count;
  logic [9:0] meas_line_len;
  logic [9:0] meas_frame_lines;

  modport master (
    output vga_hsync_in, vga_vsync_in, vga_rgb_in,
    input  rx_x, rx_y, rx_de, rx_rgb, frame_start, locked, timing_err,
           err_count, meas_line_len, meas_frame_lines
  );

  modport slave (
    input  vga_hsync_in, vga_vsync_in, vga_rgb_in,
    output rx_x, rx_y, rx_de, rx_rgb, frame_start, locked, timing_err,
           err_count, meas_line_len, meas_frame_lines
  );
endinterface

// File: rtl/vga_rx_timing_recovery.sv
// Receive side of the 640x480 VGA link: samples hsync/vsync/RGB on pixel_clk,
// recovers pixel coordinates and data-enable, measures line and frame lengths
// against nominal totals and reports lock and timing errors.
// Ports:
//   pixel_clk : pixel clock (~25 MHz)
//   reset     : asynchronous, active high
//   bus       : vga_rx_timing_recovery_if.slave (sync/pixel inputs, recovery outputs)
// Pins to rx_* outputs take 2 pixel_clk cycles.
module vga_rx_timing_recovery #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_START     = 135,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_START     = 34,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                       pixel_clk,
  input  logic                       reset,
  vga_rx_timing_recovery_if.slave    bus
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] CNT_MAX   = '1;
  localparam logic [9:0] H_TOT     = 10'(H_TOTAL);
  localparam logic [9:0] V_TOT     = 10'(V_TOTAL);
  localparam logic [9:0] H_BEG     = 10'(H_START);
  localparam logic [9:0] H_END     = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] V_BEG     = 10'(V_START);
  localparam logic [9:0] V_END     = 10'(V_START + V_ACTIVE);
  localparam logic [7:0] LOCK_N    = 8'(LOCK_FRAMES);

  // input stage and edge history
  logic       s_hs, s_vs, prev_hs, prev_vs;
  logic [7:0] s_rgb;
  logic       hs_fall, vs_fall;

  // counters
  logic [9:0] h_cnt, v_cnt, h_inc, v_inc;
  logic       vs_pend;
  logic       line_rst, line_bad, frame_bad, line_bad_chk;

  // state machine
  state_t     state, state_nxt;
  logic       err_evt;
  logic [7:0] good;
  logic [7:0] good_inc;
  logic       frame_dirty;
  logic       skip_line;

  // outputs
  logic       locked_c, act, h_win, v_win;
  logic [9:0] rx_x_q, rx_y_q, meas_line_q, meas_frame_q;
  logic [7:0] rx_rgb_q, err_count_q;
  logic       rx_de_q, frame_start_q, timing_err_q;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      s_hs    <= 1'b1;
      s_vs    <= 1'b1;
      s_rgb   <= '0;
      prev_hs <= 1'b1;
      prev_vs <= 1'b1;
    end else begin
      s_hs    <= bus.vga_hsync_in;
      s_vs    <= bus.vga_vsync_in;
      s_rgb   <= bus.vga_rgb_in;
      prev_hs <= s_hs;
      prev_vs <= s_vs;
    end
  end

  assign hs_fall  = prev_hs & ~s_hs;
  assign vs_fall  = prev_vs & ~s_vs;
  assign h_inc    = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 10'd1;
  assign v_inc    = (v_cnt == CNT_MAX) ? CNT_MAX : v_cnt + 10'd1;
  // A vsync edge arriving with or before an hsync edge restarts the frame on
  // that hsync edge.
  assign line_rst  = hs_fall & (vs_pend | vs_fall);
  assign line_bad  = hs_fall & (h_inc != H_TOT);
  assign frame_bad = line_rst & (v_inc != V_TOT);
  assign line_bad_chk = line_bad & ~skip_line;
  assign good_inc  = good + 8'd1;

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      h_cnt        <= '0;
      v_cnt        <= '0;
      vs_pend      <= 1'b0;
      meas_line_q  <= '0;
      meas_frame_q <= '0;
    end else begin
      h_cnt <= hs_fall ? '0 : h_inc;
      if (hs_fall)
        meas_line_q <= h_inc;
      if (line_rst) begin
        v_cnt        <= '0;
        vs_pend      <= 1'b0;
        meas_frame_q <= v_inc;
      end else begin
        if (hs_fall)
          v_cnt <= v_inc;
        if (vs_fall)
          vs_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset)
      state <= SEARCH;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_evt   = 1'b0;
    unique case (state)
      SEARCH: begin
        if (line_rst)
          state_nxt = VERIFY;
      end
      VERIFY: begin
        // the line closing a frame counts towards that frame
        if (line_rst) begin
          if (frame_bad || frame_dirty || line_bad_chk) begin
            err_evt   = 1'b1;
            state_nxt = SEARCH;
          end else if (good_inc == LOCK_N) begin
            state_nxt = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (line_bad || frame_bad) begin
          err_evt   = 1'b1;
          state_nxt = SEARCH;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    locked_c = (state == LOCKED);
    act      = locked_c & h_win & v_win;
  end

  // saturated counters sit at 1023, beyond both windows
  assign h_win = (h_cnt >= H_BEG) && (h_cnt < H_END);
  assign v_win = (v_cnt >= V_BEG) && (v_cnt < V_END);

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      good        <= '0;
      frame_dirty <= 1'b0;
      skip_line   <= 1'b0;
    end else if (state == SEARCH) begin
      if (line_rst) begin
        good        <= '0;
        frame_dirty <= 1'b0;
        skip_line   <= 1'b1;
      end
    end else if (state == VERIFY) begin
      if (hs_fall)
        skip_line <= 1'b0;
      if (line_rst) begin
        frame_dirty <= 1'b0;
        if (!err_evt)
          good <= good_inc;
      end else if (line_bad_chk) begin
        frame_dirty <= 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      rx_de_q       <= 1'b0;
      rx_x_q        <= '0;
      rx_y_q        <= '0;
      rx_rgb_q      <= '0;
      frame_start_q <= 1'b0;
      timing_err_q  <= 1'b0;
      err_count_q   <= '0;
    end else begin
      rx_de_q       <= act;
      rx_x_q        <= act ? h_cnt - H_BEG : '0;
      rx_y_q        <= act ? v_cnt - V_BEG : '0;
      rx_rgb_q      <= act ? s_rgb : '0;
      frame_start_q <= act & (h_cnt == H_BEG) & (v_cnt == V_BEG);
      timing_err_q  <= err_evt;
      if (err_evt && (err_count_q != '1))
        err_count_q <= err_count_q + 8'd1;
    end
  end

  assign bus.rx_x             = rx_x_q;
  assign bus.rx_y             = rx_y_q;
  assign bus.rx_de            = rx_de_q;
  assign bus.rx_rgb           = rx_rgb_q;
  assign bus.frame_start      = frame_start_q;
  assign bus.locked           = locked_c;
  assign bus.timing_err       = timing_err_q;
  assign bus.err_count        = err_count_q;
  assign bus.meas_line_len    = meas_line_q;
  assign bus.meas_frame_lines = meas_frame_q;

endmodule

// File: tb/tb_vga_rx_timing_recovery.sv
// Bench for vga_rx_timing_recovery using a reduced timing (16x10 total,
// 8x4 active) so several frames fit in a few thousand cycles. A small VGA
// generator drives the pins on the falling clock edge; results are sampled
// 1 time unit after the rising edge.
module tb_vga_rx_timing_recovery;

  localparam int unsigned HA = 8;
  localparam int unsigned HS = 4;
  localparam int unsigned HT = 16;
  localparam int unsigned VA = 4;
  localparam int unsigned VS = 2;
  localparam int unsigned VT = 10;
  localparam int unsigned HPW = 2;
  localparam int unsigned VPW = 2;
  localparam int unsigned FRAME = HT * VT;

  logic pixel_clk = 1'b0;
  logic reset     = 1'b1;

  vga_rx_timing_recovery_if vif ();

  vga_rx_timing_recovery #(
    .H_ACTIVE(HA), .H_START(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_START(VS), .V_TOTAL(VT),
    .LOCK_FRAMES(2)
  ) dut (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .bus       (vif)
  );

  always #20 pixel_clk = ~pixel_clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // generator control (main process) and position of the pin currently driven
  bit          gen_run     = 1'b0;
  bit          stretch_req = 1'b0;
  int unsigned cur_gx = 0, cur_gy = 0, cur_frame = 0;
  int unsigned terr_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return {4'b0, vif.rx_x, vif.rx_y, vif.rx_de, vif.rx_rgb, vif.frame_start,
            vif.locked, vif.timing_err, vif.err_count, vif.meas_line_len,
            vif.meas_frame_lines};
  endfunction

  function automatic int unsigned relpos(input int unsigned ref_frame);
    return (cur_frame - ref_frame) * FRAME + cur_gy * HT + cur_gx;
  endfunction

  // sel: 0 locked high, 1 locked low, 2 frame_start, 3 rx_de, 4 pin at (15,4)
  task automatic wait_for(input int unsigned sel, input int unsigned budget, output bit found);
    found = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      tick();
      case (sel)
        0: found = (vif.locked === 1'b1);
        1: found = (vif.locked === 1'b0);
        2: found = (vif.frame_start === 1'b1);
        3: found = (vif.rx_de === 1'b1);
        default: found = (cur_gx == HT - 1) && (cur_gy == 4);
      endcase
      if (found) break;
    end
  endtask

  // pattern: pixel colour equals its expected recovered x (low 8 bits)
  initial begin
    int unsigned gx, gy, line_len;
    gx = 0; gy = 0;
    vif.vga_hsync_in = 1'b1;
    vif.vga_vsync_in = 1'b1;
    vif.vga_rgb_in   = '0;
    forever begin
      @(negedge pixel_clk);
      if (gen_run) begin
        vif.vga_hsync_in = (gx < HPW) ? 1'b0 : 1'b1;
        vif.vga_vsync_in = (gy < VPW) ? 1'b0 : 1'b1;
        vif.vga_rgb_in   = 8'(gx - 1 - HS);
        cur_gx = gx;
        cur_gy = gy;
        line_len = (stretch_req && gy == 3) ? HT + 1 : HT;
        if (gx == line_len - 1) begin
          gx = 0;
          if (gy == VT - 1) begin
            gy = 0;
            cur_frame = cur_frame + 1;
          end else begin
            gy = gy + 1;
          end
        end else begin
          gx = gx + 1;
        end
      end else begin
        vif.vga_hsync_in = 1'b1;
        vif.vga_vsync_in = 1'b1;
        vif.vga_rgb_in   = '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge pixel_clk);
      if (vif.timing_err === 1'b1) terr_seen++;
    end
  end

  initial begin
    bit          found;
    int unsigned ref_f, t0, k, seq_err, rgb_err, de_hold;
    logic [9:0]  last_x, last_y;

    repeat (3) tick();
    check("reset_outs", all_outs(), 64'(0));
    reset   = 1'b0;
    gen_run = 1'b1;

    // acquisition: SEARCH entry plus two good frames
    wait_for(0, 5 * FRAME, found);
    check("lock_found", 64'(found), 64'(1));
    check("lock_pos", 64'(relpos(0)), 64'(2 * FRAME + 1));
    check("meas_line", 64'(vif.meas_line_len), 64'(HT));
    check("meas_frame", 64'(vif.meas_frame_lines), 64'(VT));
    check("err_count_lock", 64'(vif.err_count), 64'(0));

    // locked loopback over one full frame
    wait_for(2, 2 * FRAME, found);
    check("fs_found", 64'(found), 64'(1));
    check("fs_pos", 64'(cur_gy * HT + cur_gx), 64'(VS * HT + HS + 2));
    check("fs_x", 64'(vif.rx_x), 64'(0));
    check("fs_y", 64'(vif.rx_y), 64'(0));
    check("fs_rgb", 64'(vif.rx_rgb), 64'(0));
    k = 0; seq_err = 0; rgb_err = 0; last_x = '0; last_y = '0; found = 1'b0;
    for (int unsigned i = 0; i < 2 * FRAME; i++) begin
      if (vif.rx_de === 1'b1) begin
        if (vif.rx_x !== 10'(k % HA) || vif.rx_y !== 10'(k / HA)) seq_err++;
        if (vif.rx_rgb !== 8'(k % HA)) rgb_err++;
        last_x = vif.rx_x;
        last_y = vif.rx_y;
        k++;
      end
      tick();
      if (vif.frame_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("next_fs_found", 64'(found), 64'(1));
    check("de_per_frame", 64'(k), 64'(HA * VA));
    check("de_sequence", 64'(seq_err), 64'(0));
    check("de_rgb", 64'(rgb_err), 64'(0));
    check("last_x", 64'(last_x), 64'(HA - 1));
    check("last_y", 64'(last_y), 64'(VA - 1));
    check("err_count_loop", 64'(vif.err_count), 64'(0));

    // one line stretched by a cycle while locked
    ref_f = cur_frame;
    t0 = terr_seen;
    stretch_req = 1'b1;
    wait_for(1, 2 * FRAME, found);
    stretch_req = 1'b0;
    check("stretch_unlock", 64'(found), 64'(1));
    check("stretch_meas", 64'(vif.meas_line_len), 64'(HT + 1));
    check("stretch_errcnt", 64'(vif.err_count), 64'(1));
    wait_for(0, 5 * FRAME, found);
    check("stretch_relock", 64'(found), 64'(1));
    check("stretch_relock_pos", 64'(relpos(ref_f)), 64'(3 * FRAME + 1));
    check("stretch_terr", 64'(terr_seen - t0), 64'(1));

    // hsync stuck high for 2000 cycles
    wait_for(4, 2 * FRAME, found);
    check("hold_start", 64'(found), 64'(1));
    ref_f = cur_frame;
    t0 = terr_seen;
    gen_run = 1'b0;
    de_hold = 0;
    repeat (2000) begin
      tick();
      if (vif.rx_de === 1'b1) de_hold++;
    end
    check("hold_no_de", 64'(de_hold), 64'(0));
    check("hold_terr_quiet", 64'(terr_seen - t0), 64'(0));
    gen_run = 1'b1;
    wait_for(1, 50, found);
    check("hold_unlock", 64'(found), 64'(1));
    check("hold_meas", 64'(vif.meas_line_len), 64'(1023));
    check("hold_errcnt", 64'(vif.err_count), 64'(2));
    wait_for(0, 5 * FRAME, found);
    check("hold_relock_pos", 64'(relpos(ref_f)), 64'(3 * FRAME + 1));
    check("hold_terr", 64'(terr_seen - t0), 64'(1));

    // reset in the middle of an active line
    wait_for(3, 2 * FRAME, found);
    check("de_before_reset", 64'(found), 64'(1));
    reset = 1'b1;
    #1;
    check("reset_async_outs", all_outs(), 64'(0));
    repeat (3) tick();
    ref_f = cur_frame;
    reset = 1'b0;
    wait_for(0, 5 * FRAME, found);
    check("reset_relock_pos", 64'(relpos(ref_f)), 64'(3 * FRAME + 1));
    check("reset_errcnt", 64'(vif.err_count), 64'(0));
    check("reset_meas_frame", 64'(vif.meas_frame_lines), 64'(VT));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
